sram_arbiter: RTL and testbench

//  Shares one external async 8-bit SRAM between the V20 CPU bus master (cpu_bus mem strobes,
//  via a req/ack shim) and a secondary AUX master (video fetch / DMA).

---
 rtl/sram_arb_pkg.sv | 36 +++
 rtl/sram_arbiter_if.sv | 27 ++
 rtl/sram_arb_fair.sv | 57 +++++
 rtl/sram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the SRAM arbiter slice: FSM state encoding,
//   grant-owner encoding, default geometry and a counter-width helper.
//   Module parameters can override these defaults, so derived widths are
//   computed in the modules with cnt_width().
package sram_arb_pkg;

  // Requesters always present a 20-bit physical address.
  localparam int REQ_ADDR_W        = 20;
  localparam int DEF_ADDR_W        = 19;
  localparam int DEF_DATA_W        = 8;
  localparam int DEF_ACCESS_CYCLES = 2;
  localparam int DEF_MAX_CPU_RUN   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_RECOV = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_AUX = 1'b1
  } gnt_owner_e;

  // Returns the number of bits needed to hold the values 0..n-1, minimum 1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_ACCESS_CYCLES);

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Requester-side bus of the SRAM arbiter. One instance per master
//   (CPU shim, AUX fetch/DMA).
//   req    level request; wr/addr/wdata stable until ack
//   wr     1 = write, 0 = read
//   addr   20-bit physical address (arbiter uses the low ADDR_W bits)
//   wdata  write data
//   rdata  read data, valid from ack, held until the next own read ack
//   ack    one-cycle completion pulse
//   modport master: requester side; modport slave: arbiter side.
interface sram_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic                  req;
  logic                  wr;
  logic [REQ_ADDR_W-1:0] addr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W-1:0]     rdata;
  logic                  ack;

  modport master (output req, wr, addr, wdata, input rdata, ack);
  modport slave  (input req, wr, addr, wdata, output rdata, ack);

endinterface

// File: rtl/sram_arb_fair.sv
// sram_arb_fair
//   Fairness counter and winner select for the SRAM arbiter, built only
//   when SRAM_ARB_FAIR_EN is defined. Counts CPU grants made while AUX is
//   waiting; once MAX_CPU_RUN such grants have happened, the next IDLE
//   decision with AUX pending goes to AUX even if the CPU also requests.
//   Ports:
//     clk, rst_n  clock, asynchronous active-low reset
//     idle        arbiter is in IDLE (a grant decision is made this cycle)
//     cpu_req     CPU request level
//     aux_req     AUX request level
//     grant_aux   1 = AUX wins the current decision (only meaningful with a req)
`ifdef SRAM_ARB_FAIR_EN
module sram_arb_fair
  import sram_arb_pkg::*;
#(
  parameter int MAX_CPU_RUN = DEF_MAX_CPU_RUN
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle,
  input  logic cpu_req,
  input  logic aux_req,
  output logic grant_aux
);

  localparam int                FAIR_W   = cnt_width(MAX_CPU_RUN + 1);
  localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(MAX_CPU_RUN);

  logic [FAIR_W-1:0] fair_cnt_q, fair_cnt_d;
  logic              run_exhausted;

  assign run_exhausted = (fair_cnt_q >= FAIR_MAX);
  assign grant_aux     = aux_req & (~cpu_req | run_exhausted);

  // Only IDLE cycles move the counter; a CPU grant with AUX waiting counts
  // up, an AUX grant or an IDLE cycle without AUX pending clears it.
  always_comb begin
    fair_cnt_d = fair_cnt_q;
    if (idle) begin
      if (!aux_req || grant_aux) begin
        fair_cnt_d = '0;
      end else if (!run_exhausted) begin
        fair_cnt_d = fair_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fair_cnt_q <= '0;
    end else begin
      fair_cnt_q <= fair_cnt_d;
    end
  end

endmodule
`endif

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one asynchronous 8-bit SRAM between the CPU bus shim and an AUX
//   master (video fetch / DMA). Each access runs IDLE -> ACC -> RECOV:
//   ACCESS_CYCLES cycles with CE low, then one recovery cycle that returns
//   the data-bus direction to input and pulses the winner's ack.
//   Arbitration happens only in IDLE; the CPU has fixed priority.
//   Optional feature: define SRAM_ARB_FAIR_EN to bound how many CPU grants
//   in a row AUX may be kept waiting (MAX_CPU_RUN).
//   Ports:
//     iClk, iResetN       clock, asynchronous active-low reset
//     cpu_bus, aux_bus    requester buses (sram_arbiter_if.slave)
//     oSramAddr           SRAM address
//     oSramDout           SRAM write data
//     iSramDin            SRAM read data
//     oSramOe             1 = FPGA drives the SRAM data bus
//     oSramCeN/OeN/WeN    SRAM strobes, active-low
//   ACCESS_CYCLES must be at least 2 so a write has a data-hold cycle.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int MAX_CPU_RUN   = DEF_MAX_CPU_RUN
) (
  input  logic              iClk,
  input  logic              iResetN,
  sram_arbiter_if.slave     cpu_bus,
  sram_arbiter_if.slave     aux_bus,
  output logic [ADDR_W-1:0] oSramAddr,
  output logic [DATA_W-1:0] oSramDout,
  input  logic [DATA_W-1:0] iSramDin,
  output logic              oSramOe,
  output logic              oSramCeN,
  output logic              oSramOeN,
  output logic              oSramWeN
);

  localparam int               CNT_W    = cnt_width(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  gnt_owner_e        owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  logic              in_idle;
  logic              grant_aux;
  logic              cpu_ack, aux_ack;

  // Upper requester address bits select nothing in this SRAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_bus.addr[REQ_ADDR_W-1:ADDR_W],
                              aux_bus.addr[REQ_ADDR_W-1:ADDR_W]};

  assign in_idle = (state_q == ST_IDLE);

`ifdef SRAM_ARB_FAIR_EN
  sram_arb_fair #(
    .MAX_CPU_RUN (MAX_CPU_RUN)
  ) u_fair (
    .clk       (iClk),
    .rst_n     (iResetN),
    .idle      (in_idle),
    .cpu_req   (cpu_bus.req),
    .aux_req   (aux_bus.req),
    .grant_aux (grant_aux)
  );
`else
  localparam int unused_max_cpu_run = MAX_CPU_RUN;
  assign grant_aux = aux_bus.req & ~cpu_bus.req;
`endif

  // Next-state logic. The winner's operands are latched on the IDLE->ACC
  // transition so requesters may drop req early without disturbing the
  // access. Read data is captured on the last ACC cycle so it is valid in
  // RECOV alongside the ack.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (cpu_bus.req || aux_bus.req) begin
          if (grant_aux) begin
            owner_d = GNT_AUX;
            wr_d    = aux_bus.wr;
            addr_d  = aux_bus.addr[ADDR_W-1:0];
            dout_d  = aux_bus.wdata;
          end else begin
            owner_d = GNT_CPU;
            wr_d    = cpu_bus.wr;
            addr_d  = cpu_bus.addr[ADDR_W-1:0];
            dout_d  = cpu_bus.wdata;
          end
          cnt_d   = CNT_LOAD;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (cnt_q == '0) begin
          if (!wr_q) begin
            if (owner_q == GNT_AUX) begin
              aux_rdata_d = iSramDin;
            end else begin
              cpu_rdata_d = iSramDin;
            end
          end
          state_d = ST_RECOV;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RECOV: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset releases the SRAM immediately. WE is raised on the final ACC
  // cycle to give write data hold time while CE is still low.
  always_comb begin
    oSramCeN = 1'b1;
    oSramOeN = 1'b1;
    oSramWeN = 1'b1;
    oSramOe  = 1'b0;
    cpu_ack  = 1'b0;
    aux_ack  = 1'b0;
    case (state_q)
      ST_ACC: begin
        oSramCeN = 1'b0;
        if (wr_q) begin
          oSramOe  = 1'b1;
          oSramWeN = (cnt_q == '0);
        end else begin
          oSramOeN = 1'b0;
        end
      end
      ST_RECOV: begin
        if (owner_q == GNT_AUX) begin
          aux_ack = 1'b1;
        end else begin
          cpu_ack = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iResetN) begin
    if (!iResetN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      owner_q     <= GNT_CPU;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      dout_q      <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  assign oSramAddr     = addr_q;
  assign oSramDout     = dout_q;
  assign cpu_bus.rdata = cpu_rdata_q;
  assign aux_bus.rdata = aux_rdata_q;
  assign cpu_bus.ack   = cpu_ack;
  assign aux_bus.ack   = aux_ack;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Self-checking bench for sram_arbiter with a behavioural async SRAM and
//   a scoreboard of expected acks (owner + read data) filled when requests
//   are driven and drained by a monitor when acks appear.
//   Build with SRAM_ARB_FAIR_EN defined to exercise the fairness variant.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int AC      = 2;
  localparam int MAX_RUN = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  sram_arbiter_if #(.DATA_W(DATA_W)) cpu_if ();
  sram_arbiter_if #(.DATA_W(DATA_W)) aux_if ();

  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_dout;
  logic [DATA_W-1:0] sram_din = 8'hEE;
  logic              sram_oe, ce_n, oe_n, we_n;

  sram_arbiter #(
    .ADDR_W        (ADDR_W),
    .DATA_W        (DATA_W),
    .ACCESS_CYCLES (AC),
    .MAX_CPU_RUN   (MAX_RUN)
  ) dut (
    .iClk      (clk),
    .iResetN   (rst_n),
    .cpu_bus   (cpu_if),
    .aux_bus   (aux_if),
    .oSramAddr (sram_addr),
    .oSramDout (sram_dout),
    .iSramDin  (sram_din),
    .oSramOe   (sram_oe),
    .oSramCeN  (ce_n),
    .oSramOeN  (oe_n),
    .oSramWeN  (we_n)
  );

  // Behavioural SRAM: writes land while CE and WE are low with the bus
  // driven; read data is presented while CE and OE are low.
  logic [7:0] sram_mem [int];
  always @(negedge clk) begin
    if (!ce_n && !we_n && sram_oe) sram_mem[int'(sram_addr)] = sram_dout;
    if (!ce_n && !oe_n)
      sram_din = sram_mem.exists(int'(sram_addr)) ? sram_mem[int'(sram_addr)] : 8'h00;
    else
      sram_din = 8'hEE;
  end

  typedef struct packed {
    logic       is_aux;
    logic [7:0] data;
  } sb_entry_t;

  sb_entry_t  sb_q[$];
  logic [7:0] ref_mem [int];
  logic [7:0] exp_cpu_rdata = 8'h00;
  logic [7:0] exp_aux_rdata = 8'h00;
  int         checks = 0;
  int         failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit is_aux, input bit req, input bit wr,
                               input logic [19:0] addr, input logic [7:0] data);
    if (is_aux) begin
      aux_if.req = req; aux_if.wr = wr; aux_if.addr = addr; aux_if.wdata = data;
    end else begin
      cpu_if.req = req; cpu_if.wr = wr; cpu_if.addr = addr; cpu_if.wdata = data;
    end
  endtask

  // Reads expect the reference memory; writes expect the port's read data
  // to stay at its last read value.
  task automatic pushExpected(input bit is_aux, input bit wr,
                              input logic [19:0] addr, input logic [7:0] data);
    sb_entry_t e;
    int key = int'(addr[ADDR_W-1:0]);
    e.is_aux = is_aux;
    if (wr) begin
      ref_mem[key] = data;
      e.data = is_aux ? exp_aux_rdata : exp_cpu_rdata;
    end else begin
      e.data = ref_mem.exists(key) ? ref_mem[key] : 8'h00;
      if (is_aux) exp_aux_rdata = e.data;
      else        exp_cpu_rdata = e.data;
    end
    sb_q.push_back(e);
  endtask

  // Monitor: every ack pops one scoreboard entry and checks owner and data.
  always @(negedge clk) begin
    sb_entry_t e;
    if (rst_n && (cpu_if.ack || aux_if.ack)) begin
      checkOutput("ack_exclusive", cpu_if.ack & aux_if.ack, 0);
      checkOutput("ack_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        checkOutput("ack_owner", aux_if.ack, e.is_aux);
        checkOutput(e.is_aux ? "aux_rdata" : "cpu_rdata",
                    e.is_aux ? aux_if.rdata : cpu_if.rdata, e.data);
      end
    end
  end

  task automatic waitAck(input bit is_aux, input int budget, input string tag,
                         output int at_cycle);
    bit seen = 1'b0;
    at_cycle = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (is_aux ? aux_if.ack : cpu_if.ack) begin
        seen = 1'b1;
        at_cycle = cycle;
      end
    end
    checkOutput(tag, seen, 1);
  endtask

  // One uncontended access with cycle-by-cycle strobe checks; the request
  // is dropped in the cycle after the ack.
  task automatic runSingle(input bit is_aux, input bit wr,
                           input logic [19:0] addr, input logic [7:0] data);
    @(posedge clk); #1;
    pushExpected(is_aux, wr, addr, data);
    applyStimulus(is_aux, 1'b1, wr, addr, data);
    @(negedge clk);
    checkOutput("idle_ce_n", ce_n, 1);
    for (int k = 1; k <= AC; k++) begin
      @(negedge clk);
      checkOutput("acc_ce_n", ce_n, 0);
      checkOutput("acc_oe_n", oe_n, wr ? 1 : 0);
      checkOutput("acc_we_n", we_n, (wr && k < AC) ? 0 : 1);
      checkOutput("acc_bus_oe", sram_oe, wr);
      checkOutput("acc_no_ack", cpu_if.ack | aux_if.ack, 0);
      if (k == 1) begin
        checkOutput("sram_addr", sram_addr, 32'(addr[ADDR_W-1:0]));
        if (wr) checkOutput("sram_dout", sram_dout, data);
      end
    end
    @(negedge clk);
    checkOutput("recov_ce_n", ce_n, 1);
    checkOutput("recov_bus_oe", sram_oe, 0);
    checkOutput("recov_ack", is_aux ? aux_if.ack : cpu_if.ack, 1);
    @(posedge clk); #1;
    applyStimulus(is_aux, 1'b0, wr, addr, data);
  endtask

  function automatic logic [7:0] readModel(input int key);
    return sram_mem.exists(key) ? sram_mem[key] : 8'hEE;
  endfunction

  initial begin
    int c1, c2, cpu_seen, aux_seen, first_ack, second_ack, any_ack;
    int total, last_aux, max_gap;

    applyStimulus(1'b0, 1'b0, 1'b0, 20'h0, 8'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 8'h0);
    sram_mem[32'h12345] = 8'hA5; ref_mem[32'h12345] = 8'hA5;
    sram_mem[32'h00400] = 8'h5A; ref_mem[32'h00400] = 8'h5A;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ce_n", ce_n, 1);
    checkOutput("rst_oe_n", oe_n, 1);
    checkOutput("rst_we_n", we_n, 1);
    checkOutput("rst_bus_oe", sram_oe, 0);
    checkOutput("rst_cpu_ack", cpu_if.ack, 0);
    checkOutput("rst_aux_ack", aux_if.ack, 0);
    checkOutput("rst_cpu_rdata", cpu_if.rdata, 0);
    checkOutput("rst_aux_rdata", aux_if.rdata, 0);
    checkOutput("rst_sram_addr", sram_addr, 0);
    checkOutput("rst_sram_dout", sram_dout, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic reads and writes on both ports.
    runSingle(1'b0, 1'b0, 20'h12345, 8'h00);
    runSingle(1'b1, 1'b1, 20'h00010, 8'h3C);
    checkOutput("model_holds_3c", readModel(32'h10), 8'h3C);
    checkOutput("aux_rdata_after_write", aux_if.rdata, 0);
    runSingle(1'b1, 1'b0, 20'h00010, 8'h00);
    checkOutput("cpu_rdata_untouched", cpu_if.rdata, 8'hA5);
    runSingle(1'b0, 1'b1, 20'h87777, 8'h96);
    checkOutput("model_addr_trunc", readModel(32'h07777), 8'h96);
    runSingle(1'b0, 1'b0, 20'h07777, 8'h00);

    // Simultaneous requests: CPU first, AUX one access period later.
    @(posedge clk); #1;
    pushExpected(1'b0, 1'b0, 20'h12345, 8'h00);
    pushExpected(1'b1, 1'b0, 20'h00400, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h00400, 8'h00);
    waitAck(1'b0, 10, "contend_cpu_ack", c1);
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 20'h12345, 8'h00);
    waitAck(1'b1, 10, "contend_aux_ack", c2);
    checkOutput("contend_gap", c2 - c1, AC + 2);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h00400, 8'h00);
    @(posedge clk); #1;

`ifndef SRAM_ARB_FAIR_EN
    // Both held: strict priority keeps AUX waiting for 100 CPU accesses.
    for (int i = 0; i < 100; i++) pushExpected(1'b0, 1'b0, 20'h12345, 8'h00);
    pushExpected(1'b1, 1'b0, 20'h00400, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h00400, 8'h00);
    cpu_seen = 0; aux_seen = 0; first_ack = -1; second_ack = -1;
    for (int i = 0; i < 100 * (AC + 2) + 20 && cpu_seen < 100; i++) begin
      @(negedge clk);
      if (aux_if.ack) aux_seen++;
      if (cpu_if.ack) begin
        cpu_seen++;
        if (cpu_seen == 1) first_ack = cycle;
        if (cpu_seen == 2) second_ack = cycle;
        if (cpu_seen == 100) cpu_if.req = 1'b0;
      end
    end
    checkOutput("held_cpu_acks", cpu_seen, 100);
    checkOutput("aux_starved", aux_seen, 0);
    checkOutput("held_req_gap", second_ack - first_ack, AC + 2);
    waitAck(1'b1, 10, "aux_after_run", c1);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h00400, 8'h00);
`else
    // Both held: CPU x MAX_RUN then AUX x1, repeating.
    for (int i = 0; i < 20; i++)
      pushExpected((i % (MAX_RUN + 1)) == MAX_RUN, 1'b0,
                   ((i % (MAX_RUN + 1)) == MAX_RUN) ? 20'h00400 : 20'h12345, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 20'h12345, 8'h00);
    applyStimulus(1'b1, 1'b1, 1'b0, 20'h00400, 8'h00);
    total = 0; aux_seen = 0; last_aux = 0; max_gap = 0; first_ack = -1; second_ack = -1;
    for (int i = 0; i < 20 * (AC + 2) + 20 && total < 20; i++) begin
      @(negedge clk);
      if (cpu_if.ack || aux_if.ack) begin
        total++;
        if (total == 1) first_ack = cycle;
        if (total == 2) second_ack = cycle;
        if (aux_if.ack) begin
          aux_seen++;
          if (total - last_aux > max_gap) max_gap = total - last_aux;
          last_aux = total;
        end
        if (total == 20) begin
          cpu_if.req = 1'b0;
          aux_if.req = 1'b0;
        end
      end
    end
    checkOutput("fair_total", total, 20);
    checkOutput("fair_aux_count", aux_seen, 4);
    checkOutput("fair_aux_gap_ok", max_gap <= MAX_RUN + 1, 1);
    checkOutput("held_req_gap", second_ack - first_ack, AC + 2);
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset while a write is in its ACC phase: strobes release at once,
    // the access is abandoned without an ack.
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h00020, 8'h77);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset_we_n", we_n, 0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_ce_n", ce_n, 1);
    checkOutput("async_we_n", we_n, 1);
    checkOutput("async_oe_n", oe_n, 1);
    checkOutput("async_bus_oe", sram_oe, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 20'h0, 8'h00);
    any_ack = 0;
    repeat (2) begin
      @(negedge clk);
      if (cpu_if.ack || aux_if.ack) any_ack = 1;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_cpu_rdata = 8'h00;
    exp_aux_rdata = 8'h00;
    repeat (4) begin
      @(negedge clk);
      if (cpu_if.ack || aux_if.ack) any_ack = 1;
    end
    checkOutput("no_ack_after_abort", any_ack, 0);
    checkOutput("cpu_rdata_cleared", cpu_if.rdata, 0);
    runSingle(1'b0, 1'b0, 20'h12345, 8'h00);

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
